// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud divisor helper
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int uart_div(input int clock_freq, input int baud_rate, input int oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// rtl/uart_rx_oversampled_if.sv - receive-side host interface
interface uart_rx_oversampled_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - clearable divider producing a one-cycle tick
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);
endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with majority vote
// and framing/parity/overrun reporting on a valid/ready host port.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  uart_rx_oversampled_if.master  host
);
  localparam int DIV = uart_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          PAR_ON = (PARITY_EN != 0);
  localparam logic          ODD    = (PARITY_ODD != 0);

  uart_rx_state_e        state;
  logic                  sync_q;
  logic                  rx_s;
  logic [TW-1:0]         tick_idx;
  logic [BW-1:0]         bit_idx;
  logic                  samp0;
  logic                  samp1;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;

  logic tick;
  logic div_clear;
  logic majority;
  logic at_dec;
  logic at_last;
  logic par_calc;

  // Divider idles at zero so the first tick lands DIV clocks after start entry.
  assign div_clear = (state == RX_IDLE) || (state == RX_BREAK);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (div_clear),
    .tick  (tick)
  );

  assign majority = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign at_dec   = tick && (tick_idx == T_DEC);
  assign at_last  = tick && (tick_idx == T_LAST);
  assign par_calc = PAR_ON & ((^shreg ^ par_bit) != ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= uart_rx;
      rx_s   <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RX_IDLE;
      tick_idx        <= '0;
      bit_idx         <= '0;
      samp0           <= 1'b1;
      samp1           <= 1'b1;
      shreg           <= '0;
      par_bit         <= 1'b0;
      host.rx_data    <= '0;
      host.rx_valid   <= 1'b0;
      host.parity_err <= 1'b0;
      host.frame_err  <= 1'b0;
      host.overrun    <= 1'b0;
    end else begin
      host.frame_err <= 1'b0;
      host.overrun   <= 1'b0;
      if (host.rx_valid && host.rx_ready) begin
        host.rx_valid <= 1'b0;
      end

      if (tick) begin
        tick_idx <= (tick_idx == T_LAST) ? '0 : tick_idx + 1'b1;
        if (tick_idx == T_S0) samp0 <= rx_s;
        if (tick_idx == T_S1) samp1 <= rx_s;
      end

      case (state)
        RX_IDLE: begin
          tick_idx <= '0;
          bit_idx  <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (at_dec && majority) state <= RX_IDLE;
          else if (at_last)       state <= RX_DATA;
        end
        RX_DATA: begin
          if (at_dec) shreg <= {majority, shreg[DATA_WIDTH-1:1]};
          if (at_last) begin
            if (bit_idx == B_LAST) begin
              bit_idx <= '0;
              state   <= PAR_ON ? RX_PARITY : RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (at_dec)  par_bit <= majority;
          if (at_last) state   <= RX_STOP;
        end
        RX_STOP: begin
          // Decide at mid-stop and leave early so a back-to-back start edge is not missed.
          if (at_dec) begin
            if (majority) begin
              state <= RX_IDLE;
              if (!host.rx_valid || host.rx_ready) begin
                host.rx_data    <= shreg;
                host.parity_err <= par_calc;
                host.rx_valid   <= 1'b1;
              end else begin
                host.overrun <= 1'b1;
              end
            end else begin
              host.frame_err <= 1'b1;
              state          <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule
